// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin scheduler that shares one UART_TX transmitter between NREQ
// byte-producing requesters. One byte at a time is accepted over a
// valid/ready handshake. The byte is presented on o_d_in with a one-cycle
// o_tx_start pulse. The arbiter then waits for i_tx_done before it grants
// the next requester.
//
// Parameters:
//   NREQ    - number of requesters (2..8)
//   TIMEOUT - WAIT-state watchdog limit in i_clk cycles (watchdog build only)
//
// Ports:
//   i_clk        - single clock; all state updates on the rising edge
//   i_resetn     - asynchronous, active-low reset
//   i_req_valid  - [NREQ]   requester i has a byte pending
//   i_req_data   - [8*NREQ] requester i's byte on bits [8i+7:8i]
//   o_req_ready  - [NREQ]   one-hot grant; byte i is accepted when valid&ready
//   o_tx_start   - one-cycle start pulse to UART_TX
//   o_d_in       - [8] registered byte to UART_TX, held until i_tx_done
//   i_tx_done    - frame-complete pulse from UART_TX
//   o_busy       - high while a frame is being started or transmitted
//   o_grant_id   - [$clog2(NREQ)] index of the requester being served
//   o_wdog_err   - one-cycle pulse when the watchdog aborts a frame
//
// Optional feature:
//   Define UART_TX_ARB_WDOG_EN to enable the WAIT-state watchdog. Without the
//   macro, o_wdog_err is tied low and WAIT lasts until i_tx_done.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter logic [31:0] TIMEOUT = 32'd65536
) (
    input  logic                    i_clk,
    input  logic                    i_resetn,
    input  logic [NREQ-1:0]         i_req_valid,
    input  logic [8*NREQ-1:0]       i_req_data,
    output logic [NREQ-1:0]         o_req_ready,
    output logic                    o_tx_start,
    output logic [7:0]              o_d_in,
    input  logic                    i_tx_done,
    output logic                    o_busy,
    output logic [$clog2(NREQ)-1:0] o_grant_id,
    output logic                    o_wdog_err
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_last;
    logic [IDW-1:0]  r_grant_id;
    logic [7:0]      r_d_in;
    logic [IDW-1:0]  w_pick;
    logic            w_found;
    logic [NREQ-1:0] w_onehot;
    logic [7:0]      w_pick_data;
    logic            w_accept;
    logic            w_wdog_err;

    // Round-robin search: the requester after the last one served has the
    // highest priority, wrapping around modulo NREQ.
    always_comb begin : p_pick
        int unsigned idx;
        idx      = 0;
        w_found  = 1'b0;
        w_pick   = '0;
        w_onehot = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(r_last) + k) % NREQ;
            if (!w_found && i_req_valid[IDW'(idx)]) begin
                w_found = 1'b1;
                w_pick  = IDW'(idx);
            end
        end
        if (w_found) begin
            w_onehot[w_pick] = 1'b1;
        end
    end

    assign w_pick_data = i_req_data[8*w_pick +: 8];
    assign w_accept    = (r_state == S_IDLE) && w_found;

    // Ready is only offered from IDLE. It is also gated by the reset input,
    // so it is low while reset is asserted, not only after the first edge.
    assign o_req_ready = ((r_state == S_IDLE) ? w_onehot : '0) & {NREQ{i_resetn}};

    // Next-state logic. tx_done only has an effect in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done || w_wdog_err) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register. On acceptance, capture the byte and the winner index.
    // r_last and r_grant_id differ only in their reset values: r_last starts
    // at NREQ-1 so that requester 0 wins the first arbitration.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= S_IDLE;
            r_last     <= IDW'(NREQ - 1);
            r_grant_id <= '0;
            r_d_in     <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last     <= w_pick;
                r_grant_id <= w_pick;
                r_d_in     <= w_pick_data;
            end
        end
    end

`ifdef UART_TX_ARB_WDOG_EN
    localparam int CW = $clog2({1'b0, TIMEOUT} + 33'd1);

    logic [CW-1:0] r_wdog_cnt;

    // The counter is cleared in START, so it reads 0 in the first WAIT cycle
    // and reads k in the k-th cycle after WAIT entry. A tx_done that arrives
    // in the limit cycle wins over the abort.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wdog_cnt <= '0;
        end else if (r_state == S_START) begin
            r_wdog_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wdog_cnt <= r_wdog_cnt + CW'(1);
        end
    end

    assign w_wdog_err = (r_state == S_WAIT) && !i_tx_done &&
                        (r_wdog_cnt == CW'(TIMEOUT));
`else
    assign w_wdog_err = 1'b0;
`endif

    assign o_tx_start = (r_state == S_START);
    assign o_busy     = (r_state != S_IDLE);
    assign o_d_in     = r_d_in;
    assign o_grant_id = r_grant_id;
    assign o_wdog_err = w_wdog_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter with NREQ = 4 and TIMEOUT = 100.
// The bench plays the role of UART_TX itself and drives tx_done directly.
// Expected grants come from a small round-robin model: the winner is the
// first set valid bit at offsets 1..NREQ after the last winner.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        d_in;
    logic              tx_done = 1'b0;
    logic              busy;
    logic [IDW-1:0]    grant_id;
    logic              wdog_err;

    int checks = 0;
    int errors = 0;
    int modelLast = NREQ - 1;
    int startCount = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ   (NREQ),
        .TIMEOUT(32'd100)
    ) dut (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_req_valid(req_valid),
        .i_req_data (req_data),
        .o_req_ready(req_ready),
        .o_tx_start (tx_start),
        .o_d_in     (d_in),
        .i_tx_done  (tx_done),
        .o_busy     (busy),
        .o_grant_id (grant_id),
        .o_wdog_err (wdog_err)
    );

    // Count start pulses so that a test can confirm how many frames were sent.
    always @(negedge clk) begin
        if (tx_start) startCount++;
    end

    // Round-robin reference: the first valid requester after 'last', with wrap.
    function automatic int rrPick(input logic [NREQ-1:0] valid, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (valid[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehotOf(input int idx);
        logic [NREQ-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [8*NREQ-1:0] data);
        req_valid = valid;
        req_data  = data;
    endtask

    // Called in the START cycle. Spends lat extra WAIT cycles, then pulses
    // tx_done, and returns in the following IDLE cycle.
    task automatic serveFrame(input int lat);
        cyc;
        repeat (lat) cyc;
        tx_done = 1'b1;
        cyc;
        tx_done = 1'b0;
    endtask

    task automatic test_reset;
        resetn  = 1'b0;
        tx_done = 1'b0;
        applyStimulus('1, $urandom);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_ready actual=%b required=0000", req_ready);
        end
        checks++;
        if ({tx_start, busy, wdog_err} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_flags actual=%b required=000", {tx_start, busy, wdog_err});
        end
        checks++;
        if (d_in !== 8'h00 || grant_id !== 2'd0) begin
            errors++; $display("[TB] FAIL reset_regs actual=%h/%0d required=00/0", d_in, grant_id);
        end
        req_valid = '0;
        @(negedge clk);
        resetn = 1'b1;
        cyc;
        modelLast = NREQ - 1;
    endtask

    task automatic test_single_byte;
        logic [8*NREQ-1:0] data;
        data = $urandom;
        data[23:16] = 8'hA5;
        applyStimulus(4'b0100, data);
        sample;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("[TB] FAIL single_ready actual=%b required=0100", req_ready);
        end
        cyc;
        req_valid = '0;
        sample;
        checks++;
        if (tx_start !== 1'b1 || d_in !== 8'hA5 || grant_id !== 2'd2 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL single_start actual=start%b d%h g%0d b%b required=start1 dA5 g2 b1",
                               tx_start, d_in, grant_id, busy);
        end
        cyc;
        sample;
        checks++;
        if (tx_start !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL single_pulse_width actual=start%b busy%b required=start0 busy1", tx_start, busy);
        end
        repeat (3) cyc;
        tx_done = 1'b1;
        sample;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("[TB] FAIL single_busy_at_done actual=%b required=1", busy);
        end
        cyc;
        tx_done = 1'b0;
        sample;
        checks++;
        if (busy !== 1'b0 || d_in !== 8'hA5 || grant_id !== 2'd2) begin
            errors++; $display("[TB] FAIL single_after_done actual=b%b d%h g%0d required=b0 dA5 g2", busy, d_in, grant_id);
        end
        modelLast = 2;
    endtask

    task automatic test_round_robin;
        logic [7:0] order [5];
        order = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        cyc;
        modelLast = NREQ - 1;
        applyStimulus('1, 32'h4332_2110);
        for (int f = 0; f < 5; f++) begin
            sample;
            checks++;
            if (req_ready !== onehotOf(f % NREQ)) begin
                errors++; $display("[TB] FAIL rr_ready[%0d] actual=%b required=%b", f, req_ready, onehotOf(f % NREQ));
            end
            cyc;
            sample;
            checks++;
            if (d_in !== order[f] || grant_id !== IDW'(f % NREQ)) begin
                errors++; $display("[TB] FAIL rr_byte[%0d] actual=%h/%0d required=%h/%0d", f, d_in, grant_id, order[f], f % NREQ);
            end
            serveFrame($urandom_range(1, 5));
            modelLast = f % NREQ;
        end
        req_valid = '0;
    endtask

    task automatic test_handshake_order;
        logic [8*NREQ-1:0] data;
        data = $urandom;
        data[7:0]  = 8'h77;
        data[15:8] = 8'h88;
        applyStimulus(4'b0001, data);
        sample;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("[TB] FAIL hs_first_ready actual=%b required=0001", req_ready);
        end
        cyc;
        req_valid = '0;
        cyc;
        req_valid = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            sample;
            checks++;
            if (req_ready !== 4'b0000 || d_in !== 8'h77) begin
                errors++; $display("[TB] FAIL hs_wait[%0d] actual=r%b d%h required=r0000 d77", i, req_ready, d_in);
            end
            cyc;
        end
        tx_done = 1'b1;
        sample;
        checks++;
        if (req_ready[1] !== 1'b0) begin
            errors++; $display("[TB] FAIL hs_ready_at_done actual=%b required=0", req_ready[1]);
        end
        cyc;
        tx_done = 1'b0;
        sample;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("[TB] FAIL hs_ready_after_done actual=%b required=0010", req_ready);
        end
        cyc;
        req_valid = '0;
        sample;
        checks++;
        if (tx_start !== 1'b1 || d_in !== 8'h88 || grant_id !== 2'd1) begin
            errors++; $display("[TB] FAIL hs_second_start actual=s%b d%h g%0d required=s1 d88 g1", tx_start, d_in, grant_id);
        end
        serveFrame(2);
        modelLast = 1;
    endtask

    task automatic test_withdrawn;
        logic [8*NREQ-1:0] data;
        int startsBefore;
        startsBefore = startCount;
        data = $urandom;
        data[7:0] = 8'h5A;
        applyStimulus(4'b0001, data);
        sample;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("[TB] FAIL wd_ready actual=%b required=0001", req_ready);
        end
        cyc;
        req_valid = '0;
        cyc;
        cyc;
        req_valid = 4'b1000;
        sample;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("[TB] FAIL wd_ready_in_wait actual=%b required=0000", req_ready);
        end
        cyc;
        req_valid = '0;
        cyc;
        tx_done = 1'b1;
        cyc;
        tx_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample;
            checks++;
            if (req_ready !== 4'b0000 || busy !== 1'b0 || tx_start !== 1'b0) begin
                errors++; $display("[TB] FAIL wd_idle[%0d] actual=r%b b%b s%b required=r0000 b0 s0", i, req_ready, busy, tx_start);
            end
            cyc;
        end
        checks++;
        if (startCount - startsBefore !== 1 || d_in !== 8'h5A || grant_id !== 2'd0) begin
            errors++; $display("[TB] FAIL wd_frames actual=n%0d d%h g%0d required=n1 d5A g0",
                               startCount - startsBefore, d_in, grant_id);
        end
        modelLast = 0;
    endtask

    task automatic test_reset_midframe;
        logic [8*NREQ-1:0] data;
        data = $urandom;
        data[23:16] = 8'hFF;
        applyStimulus(4'b0100, data);
        sample;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("[TB] FAIL rm_ready actual=%b required=0100", req_ready);
        end
        cyc;
        req_valid = '0;
        cyc;
        repeat (4) cyc;
        resetn = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || tx_start !== 1'b0 || busy !== 1'b0 || wdog_err !== 1'b0 ||
            d_in !== 8'h00 || grant_id !== 2'd0) begin
            errors++; $display("[TB] FAIL rm_async actual=r%b s%b b%b w%b d%h g%0d required=r0000 s0 b0 w0 d00 g0",
                               req_ready, tx_start, busy, wdog_err, d_in, grant_id);
        end
        @(negedge clk);
        resetn = 1'b1;
        cyc;
        modelLast = NREQ - 1;
        req_valid = '1;
        sample;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("[TB] FAIL rm_next_grant actual=%b required=0001", req_ready);
        end
        cyc;
        req_valid = '0;
        sample;
        checks++;
        if (grant_id !== 2'd0 || tx_start !== 1'b1) begin
            errors++; $display("[TB] FAIL rm_next_start actual=g%0d s%b required=g0 s1", grant_id, tx_start);
        end
        serveFrame(2);
        modelLast = 0;
    endtask

    task automatic test_tx_done_ignored;
        tx_done = 1'b1;
        sample;
        cyc;
        tx_done = 1'b0;
        sample;
        checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            errors++; $display("[TB] FAIL ign_idle actual=b%b s%b required=b0 s0", busy, tx_start);
        end
        applyStimulus(4'b0010, $urandom);
        sample;
        checks++;
        if (req_ready !== onehotOf(rrPick(4'b0010, modelLast))) begin
            errors++; $display("[TB] FAIL ign_ready actual=%b required=0010", req_ready);
        end
        cyc;
        req_valid = '0;
        tx_done = 1'b1;
        sample;
        cyc;
        tx_done = 1'b0;
        sample;
        checks++;
        if (busy !== 1'b1 || tx_start !== 1'b0) begin
            errors++; $display("[TB] FAIL ign_start actual=b%b s%b required=b1 s0", busy, tx_start);
        end
        repeat (2) cyc;
        tx_done = 1'b1;
        cyc;
        tx_done = 1'b0;
        sample;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL ign_complete actual=%b required=0", busy);
        end
        modelLast = 1;
    endtask

    task automatic test_random_traffic;
        logic [NREQ-1:0] mask;
        logic [7:0]      expByte;
        int              exp;
        int              lat;
        for (int f = 0; f < 40; f++) begin
            req_valid = '0;
            sample;
            checks++;
            if (req_ready !== 4'b0000 || busy !== 1'b0) begin
                errors++; $display("[TB] FAIL rnd_idle[%0d] actual=r%b b%b required=r0000 b0", f, req_ready, busy);
            end
            cyc;
            mask = 4'($urandom_range(1, 15));
            applyStimulus(mask, $urandom);
            exp = rrPick(mask, modelLast);
            expByte = req_data[8*exp +: 8];
            sample;
            checks++;
            if (req_ready !== onehotOf(exp)) begin
                errors++; $display("[TB] FAIL rnd_ready[%0d] actual=%b required=%b", f, req_ready, onehotOf(exp));
            end
            cyc;
            req_valid = mask & ~onehotOf(exp);
            sample;
            checks++;
            if (tx_start !== 1'b1 || d_in !== expByte || grant_id !== IDW'(exp)) begin
                errors++; $display("[TB] FAIL rnd_start[%0d] actual=s%b d%h g%0d required=s1 d%h g%0d",
                                   f, tx_start, d_in, grant_id, expByte, exp);
            end
            lat = $urandom_range(0, 6);
            cyc;
            for (int i = 0; i < lat; i++) begin
                req_valid = 4'($urandom);
                sample;
                checks++;
                if (req_ready !== 4'b0000 || busy !== 1'b1 || tx_start !== 1'b0 || d_in !== expByte) begin
                    errors++; $display("[TB] FAIL rnd_wait[%0d] actual=r%b b%b s%b d%h required=r0000 b1 s0 d%h",
                                       f, req_ready, busy, tx_start, d_in, expByte);
                end
                cyc;
            end
            tx_done = 1'b1;
            cyc;
            tx_done = 1'b0;
            req_valid = '0;
            modelLast = exp;
        end
    endtask

    task automatic test_watchdog;
        int early;
        early = 0;
        applyStimulus(4'b0100, $urandom);
        sample;
        cyc;
        req_valid = '0;
        sample;
        cyc;
`ifdef UART_TX_ARB_WDOG_EN
        for (int k = 0; k < 100; k++) begin
            sample;
            if (wdog_err !== 1'b0 || busy !== 1'b1) early++;
            cyc;
        end
        sample;
        checks++;
        if (early !== 0) begin
            errors++; $display("[TB] FAIL wdog_early actual=%0d required=0", early);
        end
        checks++;
        if (wdog_err !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL wdog_pulse actual=w%b b%b required=w1 b1", wdog_err, busy);
        end
        cyc;
        sample;
        checks++;
        if (wdog_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL wdog_after actual=w%b b%b required=w0 b0", wdog_err, busy);
        end
        modelLast = 2;
        applyStimulus(4'b0100, $urandom);
        sample;
        cyc;
        req_valid = '0;
        cyc;
        repeat (100) cyc;
        tx_done = 1'b1;
        sample;
        checks++;
        if (wdog_err !== 1'b0) begin
            errors++; $display("[TB] FAIL wdog_done_priority actual=%b required=0", wdog_err);
        end
        cyc;
        tx_done = 1'b0;
        sample;
        checks++;
        if (wdog_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL wdog_done_after actual=w%b b%b required=w0 b0", wdog_err, busy);
        end
`else
        for (int k = 0; k < 300; k++) begin
            sample;
            if (wdog_err !== 1'b0 || busy !== 1'b1) early++;
            cyc;
        end
        checks++;
        if (early !== 0) begin
            errors++; $display("[TB] FAIL nowdog_busy_hold actual=%0d required=0", early);
        end
        tx_done = 1'b1;
        cyc;
        tx_done = 1'b0;
        sample;
        checks++;
        if (busy !== 1'b0 || wdog_err !== 1'b0) begin
            errors++; $display("[TB] FAIL nowdog_release actual=b%b w%b required=b0 w0", busy, wdog_err);
        end
`endif
        modelLast = 2;
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_round_robin;
        test_handshake_order;
        test_withdrawn;
        test_reset_midframe;
        test_tx_done_ignored;
        test_random_traffic;
        test_watchdog;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `UART_TX` transmitter between `NREQ` byte-producing requesters. It accepts one byte at a time over a valid/ready handshake, presents it to the transmitter on `d_in` with a one-cycle `tx_start` pulse, then waits for `tx_done` before granting the next requester. It sits between the bus-side producers (AHB register writes, debug sources) and `UART_TX`, whose `b_tick` comes from `BAUDGEN`.

## Interface
- `NREQ`, 4, number of requesters; legal range 2..8.
- `TIMEOUT`, 32'd65536, watchdog limit in `clk` cycles for the WAIT state; only used with `UART_TX_ARB_WDOG_EN`. Must exceed one frame: 26042 clk at 19200 baud / 50 MHz.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in `NREQ`: requester i has a byte pending.
- `req_data` in 8*`NREQ`: requester i's byte on bits [8i+7:8i].
- `req_ready` out `NREQ`: one-hot; byte i is accepted in any cycle where `req_valid[i] & req_ready[i]`.
- `tx_start` out 1: one-cycle start pulse to `UART_TX`.
- `d_in` out 8: registered byte to `UART_TX`, stable from the `tx_start` cycle until `tx_done`.
- `tx_done` in 1: frame-complete pulse from `UART_TX`.
- `busy` out 1: high in START and WAIT.
- `grant_id` out $clog2(`NREQ`): index of the requester currently being served; holds its last value in IDLE.
- `wdog_err` out 1: one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, START, WAIT.
- **IDLE**
  - `req_ready` is the combinational one-hot round-robin pick among set `req_valid` bits.
  - The search starts at `(last+1) mod NREQ`.
  - On acceptance: latch `d_in` and `grant_id`, set `last` to i, go to START.
  - No valid request: stay in IDLE, `req_ready` = 0.
- **START**
  - `tx_start` = 1 for exactly this cycle, then go to WAIT.
- **WAIT**
  - `tx_done` = 1: go to IDLE.
  - Otherwise stay in WAIT.
- `req_ready` is 0 in START and WAIT, and 0 while `resetn` is low.
- Requesters must hold `req_data` stable while `req_valid` is high and not yet accepted. Dropping `req_valid` before acceptance is legal and is simply skipped.
- `tx_done` is ignored in IDLE and START.
- Fairness: a requester waits at most `NREQ`-1 frames once its valid is high.

## Timing
- Reset values:
  - state IDLE, `last` = `NREQ`-1 (requester 0 wins first).
  - `tx_start`, `busy`, `wdog_err`, `req_ready` = 0.
  - `d_in` = 8'h00, `grant_id` = 0.
- Acceptance in cycle T:
  - `tx_start` = 1 and `d_in` valid in T+1.
  - `busy` = 1 from T+1.
- `tx_done` in cycle D:
  - IDLE in D+1, `busy` = 0 in D+1.
  - The next `req_ready` can assert in D+1, so back-to-back frames have a one-cycle arbiter gap plus `UART_TX` latency.
- `resetn` low mid-frame: immediate return to the reset values. `UART_TX` shares `resetn` and aborts its frame; the partially sent byte is lost and is not replayed.

## Configuration
- `UART_TX_ARB_WDOG_EN` defined:
  - A $clog2(`TIMEOUT`+1)-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT` with no `tx_done`: pulse `wdog_err` for one cycle and go to IDLE (byte dropped).
  - `tx_done` in the same cycle as the limit takes priority: normal completion, no error.
- `UART_TX_ARB_WDOG_EN` undefined:
  - No counter; `wdog_err` tied 0; WAIT persists until `tx_done`; `TIMEOUT` is unused.

## Test plan
- **Reset, then single byte.** `req_valid` = 4'b0100, `req_data[23:16]` = 8'hA5.
  - `req_ready` = 4'b0100 in the same cycle.
  - `tx_start` pulse next cycle with `d_in` = A5, `grant_id` = 2.
  - `tx` line shows the A5 frame; `busy` drops the cycle after `tx_done`.
- **Round robin.** All four valid with bytes 8'h10, 8'h21, 8'h32, 8'h43, each re-asserted after acceptance.
  - Transmit order 10, 21, 32, 43, 10.
  - No requester is served twice before all others.
- **Handshake ordering.** Requester 1 raises valid while a frame is in WAIT.
  - `req_ready[1]` stays 0 until the cycle after `tx_done`.
  - `d_in` is unchanged throughout WAIT.
- **Withdrawn request.** `req_valid[3]` pulses for one cycle during WAIT.
  - It is never granted.
  - Only requester 0's byte 8'h5A is sent.
- **Reset mid-frame.** `resetn` = 0 after 4 bit times of byte 8'hFF.
  - All outputs return to reset values immediately; `tx` idles high.
  - The next grant goes to requester 0.
- **Watchdog** (macro defined, `TIMEOUT` = 100, `tx_done` forced 0).
  - `wdog_err` pulses exactly 100 cycles after WAIT entry, then IDLE.
  - With the macro undefined, `busy` stays 1 indefinitely.
